rr_mux_arbiter: RTL and testbench
=================================

Name: rr_mux_arbiter

Overview:
- Round-robin arbiter and sequencer for one shared resource port, such as the memory/bus interface, with up to four requesters.
- Drives the 2-bit select of the 4:1 word multiplexer that steers requester address/data onto the shared port.
- Issues the transaction strobe and returns a per-requester acknowledge.
- Guarantees one transaction in flight, fair rotation, and bounded wait via a timeout.

Parameters:
- TIMEOUT, 16: maximum BUSY cycles before abort. 0 disables the timeout.
- CW, 5: timeout counter width. Must satisfy 2^CW > TIMEOUT.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  4  request per requester, level. Held until ack.
- mem_done  input  1  shared resource completed the current transaction (1-cycle pulse).
- sel  output  2  select for the 4:1 steering mux (requester index).
- grant  output  4  one-hot owner of the shared port.
- mem_valid  output  1  transaction strobe to the resource, high for the whole BUSY state.
- ack  output  4  one-hot, 1-cycle completion pulse to the owner.
- timeout_err  output  1  1-cycle pulse when a transaction is aborted by timeout.
- busy  output  1  high while state is BUSY.

Behaviour:
- Reset: all outputs are 0, including sel=0, grant=0, ack=0 and timeout_err=0. Internal state is reset as follows:
  - state=IDLE.
  - round-robin pointer ptr=0.
  - timeout counter cnt=0.
- Reset asserted mid-transaction aborts it silently: no ack and no err.
- All outputs are registered; there is no combinational path from inputs to outputs.
- States: IDLE and BUSY.
- IDLE → BUSY transition:
  - In IDLE, with any eligible request, pick the first req bit scanning ptr, ptr+1, ... mod 4.
  - On the next edge, register sel=winner, grant=onehot(winner), mem_valid=1, busy=1, cnt=0, and move to BUSY.
  - Latency: req sampled in cycle N gives grant/sel/mem_valid high in cycle N+1.
- Ack masking: in the IDLE cycle where ack is high, the acked requester's req bit is masked (ineligible). This prevents a stale re-grant while the requester drops req.
- BUSY:
  - sel, grant and mem_valid are held stable.
  - cnt increments each cycle, saturating.
  - req changes are ignored, including the owner dropping req; there is no cancellation.
- Completion (mem_done=1 in a BUSY cycle M):
  - At the edge, move to IDLE and set ptr=sel+1 (mod 4, 2-bit wrap 3→0).
  - In cycle M+1: ack=grant (pulse), grant=0, mem_valid=0, busy=0.
  - sel retains its last value while IDLE.
- Timeout (TIMEOUT≠0, cnt reaches TIMEOUT-1 in BUSY without mem_done):
  - Same transition as completion.
  - In addition, timeout_err=1 in the same cycle as the ack pulse.
  - The ack is still issued so the requester releases.
- Timeout precedence: mem_done in the same cycle as the timeout condition counts as normal completion, with timeout_err=0.
- mem_done while IDLE is ignored.
- Minimum repeat: back-to-back transactions are possible, but IDLE lasts at least one cycle (the ack cycle). A new grant can appear in cycle M+2 at earliest.
- Fairness: with all four requesting continuously, grant order is strict rotation. No requester waits more than 3 other transactions.

Test Plan:
- Single request:
  - Stimulus: after reset, req=0100 from cycle 0; mem_done pulse in cycle 3.
  - Response: cycle 1 grant=0100, sel=2, mem_valid=1. Cycle 4 ack=0100, grant=0, mem_valid=0. Bench drops req in cycle 4 → no regrant in cycle 5.
- Full rotation:
  - Stimulus: req=1111 held; mem_done two cycles after each grant.
  - Response: sel sequence 0,1,2,3,0; each ack one-hot matching the preceding grant; no grant overlap.
- Sparse requesters:
  - Stimulus: req=1010 held after reset.
  - Response: grants alternate sel=1, 3, 1, 3. Requesters 0 and 2 are never granted.
- Timeout:
  - Stimulus: TIMEOUT=8; req=0001; mem_done never arrives.
  - Response: exactly 8 cycles of mem_valid=1, then ack=0001 and timeout_err=1 in the same cycle; state IDLE.
  - Repeat with mem_done on the 8th BUSY cycle → ack with timeout_err=0.
- Reset mid-operation:
  - Stimulus: reset asserted during BUSY with sel=2.
  - Response: next cycle grant=0, mem_valid=0, sel=0, ack=0. With req=1111 after release, the first grant is sel=0.
- Spurious and dropped inputs:
  - Stimulus: mem_done pulses while IDLE; owner drops req mid-BUSY.
  - Response: no state change or ack for the IDLE pulse. The dropped-req transaction still completes with ack on mem_done.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux_arbiter
// Purpose  : Round-robin arbiter/sequencer for one shared port, four requesters.
// Revision : 1.0 - initial release
// ============================================================================
module rr_mux_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CW      = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       mem_done,
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       mem_valid,
    output logic [3:0] ack,
    output logic       timeout_err,
    output logic       busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [CW-1:0] C_TMO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [CW-1:0] C_CNT_MAX  = {CW{1'b1}};

    state_t      state_q;
    logic [1:0]  ptr_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]  sel_q;
    logic [3:0]  grant_q;
    logic        mem_valid_q;
    logic [3:0]  ack_q;
    logic        err_q;
    logic        busy_q;

    logic [3:0]  eligible_d;
    logic [1:0]  scan_idx;
    logic [1:0]  winner_d;
    logic        found_d;
    logic        tmo_hit_d;

    // The requester just acked is ineligible for one cycle so it can drop req.
    assign eligible_d = req & ~ack_q;

    // Scan from farthest to nearest so the nearest index to ptr wins last.
    always_comb begin
        found_d  = 1'b0;
        winner_d = ptr_q;
        scan_idx = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            scan_idx = ptr_q + 2'(i);
            if (eligible_d[scan_idx]) begin
                found_d  = 1'b1;
                winner_d = scan_idx;
            end
        end
    end

    assign tmo_hit_d = (TIMEOUT != 0) && (cnt_q == C_TMO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 2'd0;
            cnt_q       <= '0;
            sel_q       <= 2'd0;
            grant_q     <= 4'd0;
            mem_valid_q <= 1'b0;
            ack_q       <= 4'd0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ack_q <= 4'd0;
                    err_q <= 1'b0;
                    if (found_d) begin
                        state_q     <= ST_BUSY;
                        sel_q       <= winner_d;
                        grant_q     <= 4'b0001 << winner_d;
                        mem_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        cnt_q       <= '0;
                    end
                end
                ST_BUSY: begin
                    // mem_done wins over a coincident timeout.
                    if (mem_done || tmo_hit_d) begin
                        state_q     <= ST_IDLE;
                        ptr_q       <= sel_q + 2'd1;
                        ack_q       <= grant_q;
                        err_q       <= ~mem_done;
                        grant_q     <= 4'd0;
                        mem_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end else if (cnt_q != C_CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sel         = sel_q;
    assign grant       = grant_q;
    assign mem_valid   = mem_valid_q;
    assign ack         = ack_q;
    assign timeout_err = err_q;
    assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_mux_arbiter
// Purpose  : Directed + random bench for rr_mux_arbiter against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_mux_arbiter;

    localparam int TMO = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       mem_done;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       mem_valid;
    logic [3:0] ack;
    logic       timeout_err;
    logic       busy;

    rr_mux_arbiter #(.TIMEOUT(TMO), .CW(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .mem_done    (mem_done),
        .sel         (sel),
        .grant       (grant),
        .mem_valid   (mem_valid),
        .ack         (ack),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Transaction-level reference: who owns the port, how long it has held it.
    bit         m_busy;
    int         m_owner;
    int         m_ptr;
    int         m_age;
    int         m_sel;
    logic [3:0] m_ack;
    bit         m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        logic [3:0] elig;
        int         w;
        if (reset) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_age = 0;
            m_sel = 0; m_ack = 4'd0; m_err = 0;
        end else if (!m_busy) begin
            elig  = req & ~m_ack;
            m_ack = 4'd0;
            m_err = 0;
            w = -1;
            for (int k = 0; k < 4; k++)
                if (w < 0 && elig[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
            if (w >= 0) begin
                m_busy = 1; m_owner = w; m_sel = w; m_age = 0;
            end
        end else begin
            m_age++;
            if (mem_done || m_age == TMO) begin
                m_err  = !mem_done;
                m_ack  = 4'd1 << m_owner;
                m_ptr  = (m_owner + 1) % 4;
                m_busy = 0;
            end
        end
    endtask

    task automatic check_outputs();
        check("sel",         32'(sel),         32'(m_sel));
        check("grant",       32'(grant),       m_busy ? (32'd1 << m_owner) : 32'd0);
        check("mem_valid",   32'(mem_valid),   32'(m_busy));
        check("busy",        32'(busy),        32'(m_busy));
        check("ack",         32'(ack),         32'(m_ack));
        check("timeout_err", 32'(timeout_err), 32'(m_err));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        reset = 1'b1; req = 4'd0; mem_done = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic wait_grant(output int s);
        for (int n = 0; n < 10 && !busy; n++) step();
        check("grant_wait", 32'(busy), 32'd1);
        s = int'(sel);
    endtask

    // Grant already visible; finish with mem_done in the second BUSY cycle.
    task automatic finish_txn();
        step();
        mem_done = 1'b1; step();
        mem_done = 1'b0;
    endtask

    int s;
    int nvalid;

    initial begin
        do_reset();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_sel",   32'(sel),   32'd0);

        // Single request: grant one cycle after req, ack after mem_done.
        req = 4'b0100; step();
        check("single_grant", 32'(grant), 32'b0100);
        check("single_sel",   32'(sel),   32'd2);
        step(); step();
        mem_done = 1'b1; step();
        check("single_ack", 32'(ack), 32'b0100);
        mem_done = 1'b0; req = 4'd0; step();
        check("single_noregrant", 32'(grant), 32'd0);

        // Full rotation.
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant(s);
            check("rot_sel", 32'(s), 32'(i % 4));
            finish_txn();
            check("rot_ack", 32'(ack), 32'd1 << (i % 4));
        end

        // Sparse requesters.
        do_reset();
        req = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            wait_grant(s);
            check("sparse_sel", 32'(s), (i % 2 == 0) ? 32'd1 : 32'd3);
            finish_txn();
        end

        // Timeout with no mem_done.
        do_reset();
        req = 4'b0001;
        wait_grant(s);
        nvalid = 0;
        for (int n = 0; n < 20 && mem_valid; n++) begin
            nvalid++;
            step();
        end
        check("tmo_cycles", 32'(nvalid), 32'(TMO));
        check("tmo_ack",    32'(ack),    32'b0001);
        check("tmo_err",    32'(timeout_err), 32'd1);
        req = 4'd0; step();

        // mem_done on the last allowed BUSY cycle is a normal completion.
        req = 4'b0001;
        wait_grant(s);
        for (int n = 0; n < TMO - 1; n++) step();
        mem_done = 1'b1; step();
        mem_done = 1'b0;
        check("tmo_edge_ack", 32'(ack), 32'b0001);
        check("tmo_edge_err", 32'(timeout_err), 32'd0);
        req = 4'd0; step();

        // Reset during BUSY.
        do_reset();
        req = 4'b0100;
        wait_grant(s);
        check("mid_sel", 32'(s), 32'd2);
        step();
        reset = 1'b1; step();
        check("mid_grant", 32'(grant), 32'd0);
        check("mid_sel0",  32'(sel),   32'd0);
        reset = 1'b0; req = 4'b1111;
        wait_grant(s);
        check("mid_first", 32'(s), 32'd0);
        finish_txn();

        // Spurious mem_done in IDLE, owner drops req mid-BUSY.
        req = 4'd0; step();
        mem_done = 1'b1; step();
        mem_done = 1'b0;
        check("spur_busy", 32'(busy), 32'd0);
        check("spur_ack",  32'(ack),  32'd0);
        req = 4'b0010;
        wait_grant(s);
        req = 4'd0; step(); step();
        mem_done = 1'b1; step();
        mem_done = 1'b0;
        check("drop_ack", 32'(ack), 32'b0010);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            reset    = ($urandom_range(0, 63) == 0);
            req      = 4'($urandom_range(0, 15));
            mem_done = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
